boot_rom_bus_if: RTL

BOOT_ROM_BUS_IF -- requirements
Module: boot_rom_bus_if

---
 rtl/boot_rom_pkg.sv | 15 +
 rtl/boot_rom_bus_if_if.sv | 26 ++
 rtl/boot_rom_resp_fifo.sv | 54 +++++
 rtl/boot_rom_bus_if.sv | 97 +++++++++
 4 files changed

// File: rtl/boot_rom_pkg.sv
// Shared types and defaults for the boot ROM bus slave.
// Response entries carry an error flag alongside the read word.
package boot_rom_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam logic [31:0] BASE_ADDR_DEF  = 32'h0000_8000;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  localparam resp_t RESP_ERR = '{err: 1'b1, data: 32'h0};

endpackage

// File: rtl/boot_rom_bus_if_if.sv
// Request/response bus between a core master and the boot ROM slave.
// Signal names keep the slave-side _i/_o suffixes.
interface boot_rom_bus_if_if;

  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/boot_rom_resp_fifo.sv
// Two-entry response FIFO with 1-bit wrapping pointers.
// A push while full is accepted only together with a pop.
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  resp_t      wdata,
  input  logic       pop,
  output resp_t      rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  resp_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/boot_rom_bus_if.sv
// Boot ROM bus slave: decodes requests, drives the ROM wrapper and
// returns in-order responses with a bypass path and 2-deep buffer.
module boot_rom_bus_if
  import boot_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  boot_rom_bus_if_if.slave      bus,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

  localparam logic [32:0] WIN_END =
    {1'b0, BASE_ADDR} + (33'd1 << ADDR_WIDTH);

  logic [31:0] offset;
  logic        hit;
  logic        accept;
  logic        inflight;
  logic        inflight_err;
  logic [2:0]  outstanding;

  resp_t       new_resp;
  resp_t       fifo_head;
  resp_t       head;
  logic        rvalid;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_count;
  logic        push;
  logic        pop;
  logic        unused_bus;

  // 33-bit compare so windows near the top of memory cannot wrap
  assign offset = bus.addr_i - BASE_ADDR;
  assign hit    = !bus.we_i
               && (bus.addr_i[1:0] == 2'b00)
               && ({1'b0, bus.addr_i} >= {1'b0, BASE_ADDR})
               && ({1'b0, bus.addr_i} <  WIN_END);

  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight};
  assign bus.gnt_o   = !rst && (outstanding < 3'd2);
  assign accept      = bus.req_i && bus.gnt_o;

  assign rom_en_o   = accept && hit;
  assign rom_addr_o = rom_en_o ? offset[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight     <= accept;
      inflight_err <= accept && !hit;
    end
  end

  assign new_resp = inflight_err ? RESP_ERR
                                 : '{err: 1'b0, data: rom_rdata_i};

  // Empty buffer: present last cycle's response straight through
  always_comb begin
    head   = fifo_head;
    rvalid = 1'b1;
    if (fifo_empty) begin
      head   = new_resp;
      rvalid = inflight;
    end
  end

  assign pop  = !fifo_empty && bus.rready_i;
  assign push = inflight && !(fifo_empty && bus.rready_i);

  boot_rom_resp_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (new_resp),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rvalid ? head.data : '0;
  assign bus.err_o    = rvalid && head.err;

  assign unused_bus = ^{bus.be_i, bus.wdata_i, offset, fifo_full};

endmodule
